merge_unit: RTL and testbench



---
 rtl/merge_unit.sv | 183 ++++++++++++++++++
 tb/tb_merge_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/merge_unit.sv
// rtl/merge_unit.sv - two-way sorted run merger with registered output stage and run counter
module merge_unit #(
    parameter int W          = 32,
    parameter int KEY_W      = 32,
    parameter int DESCENDING = 0,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [W-1:0]     i_a_data,
    input  logic             i_a_valid,
    input  logic             i_a_eos,
    output logic             o_a_ready,
    input  logic [W-1:0]     i_b_data,
    input  logic             i_b_valid,
    input  logic             i_b_eos,
    output logic             o_b_ready,
    output logic [W-1:0]     o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_done,
    output logic [CNT_W-1:0] o_run_count
);

    typedef enum logic [1:0] {
        S_MERGE  = 2'd0,
        S_A_HOLD = 2'd1,
        S_B_HOLD = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             a_eos_q, a_eos_d;
    logic             b_eos_q, b_eos_d;
    logic [W-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             adv;
    logic [KEY_W-1:0] a_key, b_key;
    logic             a_term, b_term;
    logic             pick_a;
    logic             a_take, b_take;
    logic             emit, emit_term, run_end;
    logic [W-1:0]     emit_data;

    assign a_key  = i_a_data[KEY_W-1:0];
    assign b_key  = i_b_data[KEY_W-1:0];
    assign a_term = (a_key == '0);
    assign b_term = (b_key == '0);
    // Ties always favour A so equal keys keep stream-A-first ordering.
    assign pick_a = (DESCENDING != 0) ? (a_key >= b_key) : (a_key <= b_key);
    assign adv    = ~valid_q | i_ready;

    always_comb begin
        state_d   = state_q;
        a_eos_d   = a_eos_q;
        b_eos_d   = b_eos_q;
        data_d    = data_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        a_take    = 1'b0;
        b_take    = 1'b0;
        emit      = 1'b0;
        emit_term = 1'b0;
        run_end   = 1'b0;
        emit_data = '0;

        if (adv) begin
            valid_d = 1'b0;
            case (state_q)
                S_MERGE: begin
                    if (i_a_valid && i_b_valid) begin
                        if (!a_term && !b_term) begin
                            emit = 1'b1;
                            if (pick_a) begin
                                a_take    = 1'b1;
                                emit_data = i_a_data;
                            end else begin
                                b_take    = 1'b1;
                                emit_data = i_b_data;
                            end
                        end else if (a_term && !b_term) begin
                            a_take  = 1'b1;
                            a_eos_d = a_eos_q | i_a_eos;
                            state_d = S_A_HOLD;
                        end else if (!a_term && b_term) begin
                            b_take  = 1'b1;
                            b_eos_d = b_eos_q | i_b_eos;
                            state_d = S_B_HOLD;
                        end else begin
                            a_take    = 1'b1;
                            b_take    = 1'b1;
                            a_eos_d   = a_eos_q | i_a_eos;
                            b_eos_d   = b_eos_q | i_b_eos;
                            emit      = 1'b1;
                            emit_term = 1'b1;
                            emit_data = i_a_data;
                            run_end   = 1'b1;
                        end
                    end
                end
                S_A_HOLD: begin
                    if (i_b_valid) begin
                        b_take    = 1'b1;
                        emit      = 1'b1;
                        emit_data = i_b_data;
                        if (b_term) begin
                            b_eos_d   = b_eos_q | i_b_eos;
                            emit_term = 1'b1;
                            run_end   = 1'b1;
                        end
                    end
                end
                S_B_HOLD: begin
                    if (i_a_valid) begin
                        a_take    = 1'b1;
                        emit      = 1'b1;
                        emit_data = i_a_data;
                        if (a_term) begin
                            a_eos_d   = a_eos_q | i_a_eos;
                            emit_term = 1'b1;
                            run_end   = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (emit) begin
                valid_d = 1'b1;
                data_d  = emit_data;
            end
            if (emit_term) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Uses the freshly updated eos flags so the final terminator lands directly in DONE.
            if (run_end) begin
                case ({a_eos_d, b_eos_d})
                    2'b11: begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                    2'b10:   state_d = S_A_HOLD;
                    2'b01:   state_d = S_B_HOLD;
                    default: state_d = S_MERGE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_MERGE;
            a_eos_q <= 1'b0;
            b_eos_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_eos_q <= a_eos_d;
            b_eos_q <= b_eos_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Readies are forced low while reset is held, independent of the clock.
    assign o_a_ready   = i_rst_n & a_take;
    assign o_b_ready   = i_rst_n & b_take;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_done      = done_q;
    assign o_run_count = cnt_q;

endmodule

// File: tb/tb_merge_unit.sv
// tb/tb_merge_unit.sv - directed self-checking bench for merge_unit
module tb_merge_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_data, b_data;
    logic        a_valid, a_eos, b_valid, b_eos;
    logic        rdy;

    logic [31:0] asc_data, desc_data, wrap_data;
    logic        asc_valid, desc_valid, wrap_valid;
    logic        asc_done, desc_done, wrap_done;
    logic        asc_ar, asc_br, desc_ar, desc_br, wrap_ar, wrap_br;
    logic [15:0] asc_cnt, desc_cnt;
    logic [1:0]  wrap_cnt;

    logic [31:0] s_data;
    logic        s_valid, s_done, s_a_ready, s_b_ready;
    logic [15:0] s_cnt;
    int          sel;

    int total = 0;
    int bad   = 0;

    logic [31:0] qa[$], qb[$], out_q[$], exp_q[$];
    bit          qa_e[$], qb_e[$];
    int          bubbles;

    always #5 clk = ~clk;

    merge_unit #(.W(32), .KEY_W(32), .DESCENDING(0), .CNT_W(16)) u_asc (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_data(a_data), .i_a_valid(a_valid), .i_a_eos(a_eos), .o_a_ready(asc_ar),
        .i_b_data(b_data), .i_b_valid(b_valid), .i_b_eos(b_eos), .o_b_ready(asc_br),
        .o_data(asc_data), .o_valid(asc_valid), .i_ready(rdy),
        .o_done(asc_done), .o_run_count(asc_cnt)
    );

    merge_unit #(.W(32), .KEY_W(16), .DESCENDING(1), .CNT_W(16)) u_desc (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_data(a_data), .i_a_valid(a_valid), .i_a_eos(a_eos), .o_a_ready(desc_ar),
        .i_b_data(b_data), .i_b_valid(b_valid), .i_b_eos(b_eos), .o_b_ready(desc_br),
        .o_data(desc_data), .o_valid(desc_valid), .i_ready(rdy),
        .o_done(desc_done), .o_run_count(desc_cnt)
    );

    merge_unit #(.W(32), .KEY_W(32), .DESCENDING(0), .CNT_W(2)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_data(a_data), .i_a_valid(a_valid), .i_a_eos(a_eos), .o_a_ready(wrap_ar),
        .i_b_data(b_data), .i_b_valid(b_valid), .i_b_eos(b_eos), .o_b_ready(wrap_br),
        .o_data(wrap_data), .o_valid(wrap_valid), .i_ready(rdy),
        .o_done(wrap_done), .o_run_count(wrap_cnt)
    );

    always_comb begin
        s_data = asc_data; s_valid = asc_valid; s_done = asc_done;
        s_a_ready = asc_ar; s_b_ready = asc_br; s_cnt = asc_cnt;
        case (sel)
            1: begin
                s_data = desc_data; s_valid = desc_valid; s_done = desc_done;
                s_a_ready = desc_ar; s_b_ready = desc_br; s_cnt = desc_cnt;
            end
            2: begin
                s_data = wrap_data; s_valid = wrap_valid; s_done = wrap_done;
                s_a_ready = wrap_ar; s_b_ready = wrap_br; s_cnt = {14'd0, wrap_cnt};
            end
            default: begin
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_heads();
        a_valid = (qa.size() != 0);
        a_data  = a_valid ? qa[0] : 32'd0;
        a_eos   = a_valid ? qa_e[0] : 1'b0;
        b_valid = (qb.size() != 0);
        b_data  = b_valid ? qb[0] : 32'd0;
        b_eos   = b_valid ? qb_e[0] : 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        qa.delete(); qa_e.delete(); qb.delete(); qb_e.delete();
        drive_heads();
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run(input int stall_at, input int stop_after);
        bit          fire_a, fire_b, seen, finished;
        logic [31:0] held;
        out_q.delete();
        bubbles  = 0;
        seen     = 1'b0;
        finished = 1'b0;
        held     = 32'd0;
        drive_heads();
        for (int cyc = 0; cyc < 300; cyc++) begin
            rdy = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            @(negedge clk);
            if (!rdy) begin
                if (cyc == stall_at) held = s_data;
                check_eq("stall_hold", {29'd0, s_valid, s_a_ready, s_b_ready, s_data},
                         {29'd0, 1'b1, 2'b00, held});
            end
            fire_a = a_valid & s_a_ready;
            fire_b = b_valid & s_b_ready;
            if (s_valid) seen = 1'b1;
            if (s_valid && rdy) out_q.push_back(s_data);
            else if (seen && rdy && !s_valid && !s_done) bubbles++;
            if (stop_after > 0 && out_q.size() >= stop_after) begin
                finished = 1'b1;
                break;
            end
            if (s_done && !s_valid) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (fire_a) begin void'(qa.pop_front()); void'(qa_e.pop_front()); end
            if (fire_b) begin void'(qb.pop_front()); void'(qb_e.pop_front()); end
            drive_heads();
        end
        if (!finished) check_eq("run_timeout", 64'd0, 64'd1);
    endtask

    task automatic cmp_out(input string tag);
        check_eq({tag, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), {32'd0, out_q[i]}, {32'd0, exp_q[i]});
    endtask

    task automatic load_s1();
        qa = '{32'd1, 32'd4, 32'd7, 32'd0}; qa_e = '{0, 0, 0, 1};
        qb = '{32'd2, 32'd3, 32'd9, 32'd0}; qb_e = '{0, 0, 0, 1};
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd7, 32'd9, 32'd0};
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; sel = 0;
        a_data = 0; a_valid = 0; a_eos = 0; b_data = 0; b_valid = 0; b_eos = 0;

        do_reset();
        check_eq("rst_valid", {63'd0, s_valid}, 64'd0);
        check_eq("rst_data",  {32'd0, s_data}, 64'd0);
        check_eq("rst_cnt",   {48'd0, s_cnt}, 64'd0);
        check_eq("rst_done",  {63'd0, s_done}, 64'd0);

        // Ascending merge
        load_s1();
        run(-1, 0);
        cmp_out("asc");
        check_eq("asc_bubbles", 64'(bubbles), 64'd1);
        check_eq("asc_done", {63'd0, s_done}, 64'd1);
        check_eq("asc_cnt", {48'd0, s_cnt}, 64'd1);

        // Backpressure mid-stream
        do_reset();
        load_s1();
        run(3, 0);
        cmp_out("bp");
        check_eq("bp_cnt", {48'd0, s_cnt}, 64'd1);

        // Unequal runs
        do_reset();
        qa = '{32'd3, 32'd0}; qa_e = '{0, 1};
        qb = '{32'd1, 32'd0, 32'd8, 32'd6, 32'd0}; qb_e = '{0, 0, 0, 0, 1};
        exp_q = '{32'd1, 32'd3, 32'd0, 32'd8, 32'd6, 32'd0};
        run(-1, 0);
        cmp_out("uneq");
        check_eq("uneq_cnt", {48'd0, s_cnt}, 64'd2);
        check_eq("uneq_done", {63'd0, s_done}, 64'd1);

        // Descending with ties; upper half tags the source stream
        sel = 1;
        do_reset();
        qa = '{32'h000A_0005, 32'h000A_0005, 32'h000A_0000}; qa_e = '{0, 0, 1};
        qb = '{32'h000B_0005, 32'h000B_0002, 32'h000B_0000}; qb_e = '{0, 0, 1};
        exp_q = '{32'h000A_0005, 32'h000A_0005, 32'h000B_0005, 32'h000B_0002, 32'h000B_0000};
        run(-1, 0);
        cmp_out("tie");
        check_eq("tie_cnt", {48'd0, s_cnt}, 64'd1);

        do_reset();
        qa = '{32'd8, 32'd3, 32'd0}; qa_e = '{0, 0, 1};
        qb = '{32'd6, 32'd5, 32'd0}; qb_e = '{0, 0, 1};
        exp_q = '{32'd8, 32'd6, 32'd5, 32'd3, 32'd0};
        run(-1, 0);
        cmp_out("desc");

        // Asynchronous reset mid-merge, then a fresh stream
        sel = 0;
        do_reset();
        load_s1();
        run(-1, 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, s_valid}, 64'd0);
        check_eq("arst_data",  {32'd0, s_data}, 64'd0);
        check_eq("arst_cnt",   {48'd0, s_cnt}, 64'd0);
        check_eq("arst_done",  {63'd0, s_done}, 64'd0);
        check_eq("arst_ready", {62'd0, s_a_ready, s_b_ready}, 64'd0);
        do_reset();
        load_s1();
        run(-1, 0);
        cmp_out("fresh");
        check_eq("fresh_cnt", {48'd0, s_cnt}, 64'd1);

        // Counter wrap with a 2-bit counter
        sel = 2;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            qa.push_back(32'd1); qa_e.push_back(1'b0);
            qa.push_back(32'd0); qa_e.push_back(i == 4);
            qb.push_back(32'd2); qb_e.push_back(1'b0);
            qb.push_back(32'd0); qb_e.push_back(i == 4);
            exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd0);
        end
        run(-1, 0);
        cmp_out("wrap");
        check_eq("wrap_cnt", {48'd0, s_cnt}, 64'd1);
        check_eq("wrap_done", {63'd0, s_done}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
